fifo_read_ctrl: RTL

//  Read-side pointer/flag controller for the dual-clock 8-entry FIFO, in the read_clk domain.
//  - Drives the FIFO memory read port (read_addr, read_enable).
//  - Synchronises the write domain's Gray write pointer and derives empty and fill level.
//  - Returns its own Gray read pointer to the write-side controller for full detection.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_read_ctrl_if.sv | 25 ++
 rtl/ptr_sync.sv | 31 +++
 rtl/fifo_read_ctrl.sv | 78 +++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for both controllers of the dual-clock 8-entry FIFO.
// Provides the pointer geometry and the Gray/binary conversions used on each side.
package fifo_pkg;

    localparam int FIFO_ADDR_W = 3;
    localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;

    typedef logic [FIFO_PTR_W-1:0] fifo_ptr_t;

    function automatic fifo_ptr_t bin2gray(input fifo_ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic fifo_ptr_t gray2bin(input fifo_ptr_t gray);
        fifo_ptr_t bin;
        bin[FIFO_PTR_W-1] = gray[FIFO_PTR_W-1];
        for (int i = FIFO_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// Read-side signal bundle of the dual-clock FIFO: pointer exchange, memory port and consumer flags.
// The master modport is the controller; the slave modport is its environment.
interface fifo_read_ctrl_if #(
    parameter int PTR_W = fifo_pkg::FIFO_PTR_W
);
    logic [PTR_W-1:0] write_ptr_gray;
    logic             rd_req;
    logic [PTR_W-1:0] read_addr;
    logic             read_enable;
    logic [PTR_W-1:0] read_ptr_gray;
    logic             empty;
    logic             rd_valid;
    logic [PTR_W-1:0] rd_level;
    logic             underflow;

    modport master (
        input  write_ptr_gray, rd_req,
        output read_addr, read_enable, read_ptr_gray, empty, rd_valid, rd_level, underflow
    );

    modport slave (
        output write_ptr_gray, rd_req,
        input  read_addr, read_enable, read_ptr_gray, empty, rd_valid, rd_level, underflow
    );
endinterface

// File: rtl/ptr_sync.sv
// Plain multi-flop synchroniser for a Gray pointer crossing into the local clock domain.
// Shared by both FIFO controllers; nothing but flops sits in the chain.
module ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int SYNC_N = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_chain [SYNC_N];

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_N; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= i_async;
            for (int i = 1; i < SYNC_N; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_sync = r_chain[SYNC_N-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side pointer/flag controller of the dual-clock 8-entry FIFO (read_clk domain).
// Owns the read pointer, derives empty/level from the synchronised write pointer, flags underflow.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int PTR_W  = ADDR_W + 1,
    parameter int SYNC_N = 2
) (
    input logic              read_clk,
    input logic              read_rst_n,
    fifo_read_ctrl_if.master bus
);

    logic [PTR_W-1:0] r_rbin;
    logic [PTR_W-1:0] r_rptr_gray;
    logic             r_empty;
    logic             r_rd_valid;
    logic [PTR_W-1:0] r_level;
    logic             r_underflow;

    logic [PTR_W-1:0] w_wq_gray;
    logic             w_pop;
    logic [PTR_W-1:0] w_rbin_next;
    logic             w_empty_next;
    logic [PTR_W-1:0] w_level_next;

    ptr_sync #(
        .WIDTH  (PTR_W),
        .SYNC_N (SYNC_N)
    ) u_wptr_sync (
        .clk     (read_clk),
        .rst_n   (read_rst_n),
        .i_async (bus.write_ptr_gray),
        .o_sync  (w_wq_gray)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_pop        = 1'b0;
        w_rbin_next  = r_rbin;
        w_empty_next = 1'b1;
        w_level_next = '0;

        // Reset masks the pop so no memory read fires in the reset cycle itself.
        w_pop        = bus.rd_req & ~r_empty & read_rst_n;
        w_rbin_next  = r_rbin + {{(PTR_W-1){1'b0}}, w_pop};
        w_empty_next = (bin2gray(w_rbin_next) == w_wq_gray);
        w_level_next = gray2bin(w_wq_gray) - w_rbin_next;
    end

    always_ff @(posedge read_clk) begin
        if (!read_rst_n) begin
            r_rbin      <= '0;
            r_rptr_gray <= '0;
            r_empty     <= 1'b1;
            r_rd_valid  <= 1'b0;
            r_level     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_rbin      <= w_rbin_next;
            r_rptr_gray <= bin2gray(w_rbin_next);
            r_empty     <= w_empty_next;
            r_rd_valid  <= w_pop;
            r_level     <= w_level_next;
            r_underflow <= bus.rd_req & r_empty;
        end
    end

    assign bus.read_addr     = r_rbin;
    assign bus.read_enable   = w_pop;
    assign bus.read_ptr_gray = r_rptr_gray;
    assign bus.empty         = r_empty;
    assign bus.rd_valid      = r_rd_valid;
    assign bus.rd_level      = r_level;
    assign bus.underflow     = r_underflow;

endmodule
